ram_responder: RTL and testbench
================================

# ram_responder

Latency-modelled word RAM on the RAM side of the bus, opposite the memory controller. It accepts the controller's single-word read and write requests and answers through `ramstate` and `ramload`: `BUSY` for a programmable number of cycles, then `ACCESS` for exactly one cycle. During that `ACCESS` cycle, read data is valid and a write commits. It exercises the controller's wait and arbitration paths under realistic memory latency.

## Interface
Parameters:
- `LAT`, default 2 — cycles from first sight of a request to `ACCESS`; legal range 1..15.
- `ADDR_W`, default 10 — word-index width; depth is 2^ADDR_W words.

Ports:
- `CLK` — input, 1 — clock. Single clock; all state updates on the rising edge.
- `nRST` — input, 1 — reset, asynchronous, active-low.
- `ramREN` — input, 1 — read request, held until `ACCESS` is seen.
- `ramWEN` — input, 1 — write request, held until `ACCESS` is seen.
- `ramaddr` — input, 32 — byte address; word index is `ramaddr[ADDR_W+1:2]`.
- `ramstore` — input, 32 — write data, sampled in the `ACCESS` cycle.
- `ramload` — output, 32 — read data; valid only in `ACCESS` of a read, 0 otherwise.
- `ramstate` — output, `ramstate_t` — one of `FREE`, `BUSY`, `ACCESS`, `ERROR`.

## Operation
Internal state:
- `phase` — `IDLE` or `WAIT`.
- `cnt` — 4-bit down counter.
- Latched request: `lat_addr` (32 bits) and `lat_op` (read or write).

A request is legal when exactly one of `ramREN` / `ramWEN` is set, `ramaddr[1:0]==0`, and `ramaddr[31:ADDR_W+2]==0`.

`ramstate` is combinational, evaluated in this priority order:
1. Both enables set, or an enable set with an illegal address → `ERROR`. Nothing is latched, `phase` goes to `IDLE`, nothing is written.
2. No enable set → `FREE`.
3. `phase==WAIT`, `cnt==0`, `ramaddr==lat_addr` and the current op equals `lat_op` → `ACCESS`.
4. Otherwise → `BUSY`.

FSM transitions:
- `IDLE` with a legal request: latch address and op, load `cnt=LAT-1`, go to `WAIT`.
- `IDLE` with no request or an illegal request: stay in `IDLE`.
- `WAIT` with no enable: go to `IDLE` (request abandoned, no write).
- `WAIT` with a legal request that mismatches the latched address or op: relatch, reload `cnt=LAT-1`, stay in `WAIT`. The controller switching requestors restarts the latency count.
- `WAIT` with a match and `cnt!=0`: decrement `cnt`.
- `WAIT` with a match and `cnt==0`: this is the `ACCESS` cycle. For a write, `mem[idx] <= ramstore` at the closing edge. The next state is `IDLE`.

Further rules:
- A request still asserted after `ACCESS` (the next word, or the same word again) is a new transaction and pays the full latency again.
- Read in `ACCESS`: `ramload = mem[idx]` combinationally.
- Reset does not alter array contents. Simulation initial contents are all 0.

## Timing
- Reset values: `phase=IDLE`, `cnt=0`, latches 0, `ramload=0`. `ramstate` is `FREE` while no enable is set.
- Latency: a request first present in cycle 0 is `BUSY` in cycles 0..LAT-1 and `ACCESS` in cycle LAT. Throughput is one word per LAT+1 cycles.
- Read-after-write to the same index: a read starting the cycle after the write's `ACCESS` returns the new data.
- Reset asserted mid-`WAIT`: return to `IDLE` immediately, and a pending write does not commit. Reset asserted on the `ACCESS` edge also suppresses the write.
- `ramstore` changing during `BUSY` does not restart the count. Only the value present in the `ACCESS` cycle is written.

## Structure
- `ramstate_t` and `word_t` (32-bit) live in `cpu_types_pkg`, not redefined locally.
- Storage goes in a sub-module `ram_array`: a 2^ADDR_W×32 array with a combinational read port and one synchronous write port (`we`, `widx`, `wdata`). `ram_responder` holds only the FSM, counter, latches and legality checks.

## Test plan
- Write then read, LAT=2:
  - `ramWEN`, `ramaddr=0x10`, `ramstore=0xDEADBEEF` → `BUSY` in cycles 0–1, `ACCESS` in cycle 2.
  - Next, `ramREN` at `0x10` → `ACCESS` 2 cycles later with `ramload=0xDEADBEEF`; `ramload=0` in every other cycle.
- Address change mid-`BUSY`, LAT=3: read `0x20` for 2 cycles, then read `0x24` → count restarts, `ACCESS` occurs exactly 3 cycles after the switch, and returns `mem[9]`.
- Both enables set, or `ramaddr=0x12` → `ERROR` in the same cycle, and a following read shows the target word unchanged.
- Back-to-back, LAT=1: reads at `0x0` then `0x4` held continuously → `ACCESS` every 2nd cycle, with correct data each time.
- Reset mid-transaction: write `0x40=0x1234`, pulse `nRST` low in cycle 1 → `ramstate=FREE` with enables low after reset, and reading `0x40` returns the old value 0.
- Abandon: `ramREN` dropped in `WAIT` → `FREE` in the next cycle, and a new request pays the full LAT.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU bus types.
// Word and RAM handshake state definitions.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  typedef enum logic {
    IDLE,
    WAIT
  } phase_t;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_t;

endpackage

// File: rtl/ram_array.sv
// Word storage for ram_responder.
// Combinational read port, one synchronous write port.
module ram_array
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              CLK,
  input  logic              we,
  input  logic [ADDR_W-1:0] widx,
  input  word_t             wdata,
  input  logic [ADDR_W-1:0] ridx,
  output word_t             rdata
);

  word_t mem [2**ADDR_W];

  always_ff @(posedge CLK) begin
    if (we) begin
      mem[widx] <= wdata;
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/ram_responder.sv
// Latency-modelled word RAM answering the memory controller.
// BUSY for LAT cycles, then ACCESS for one cycle.
module ram_responder
  import cpu_types_pkg::*;
#(
  parameter int LAT    = 2,
  parameter int ADDR_W = 10
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      ramREN,
  input  logic      ramWEN,
  input  word_t     ramaddr,
  input  word_t     ramstore,
  output word_t     ramload,
  output ramstate_t ramstate
);

  localparam logic [3:0] LOAD = 4'(LAT - 1);

  phase_t     phase;
  logic [3:0] cnt;
  word_t      lat_addr;
  op_t        lat_op;

  logic              any_en;
  logic              addr_ok;
  logic              legal;
  logic              bad;
  logic              match;
  logic              relatch;
  logic              count;
  logic              done;
  op_t               cur_op;
  logic [ADDR_W-1:0] idx;
  logic              we;
  word_t             rdata;

  assign any_en  = ramREN | ramWEN;
  assign addr_ok = (ramaddr[1:0] == 2'b00)
                && (ramaddr[31:ADDR_W+2] == '0);
  assign legal   = (ramREN ^ ramWEN) & addr_ok;
  assign bad     = any_en & ~legal;
  assign cur_op  = ramWEN ? OP_WR : OP_RD;
  assign idx     = ramaddr[ADDR_W+1:2];

  assign match   = legal
                && (phase == WAIT)
                && (ramaddr == lat_addr)
                && (cur_op == lat_op);
  assign relatch = legal & ~match;
  assign count   = match & (cnt != 4'd0);
  assign done    = match & (cnt == 4'd0);

  // Gate on nRST so a reset landing on the ACCESS edge drops the write.
  assign we = done & (cur_op == OP_WR) & nRST;

  always_comb begin
    ramstate = BUSY;
    if (bad) begin
      ramstate = ERROR;
    end else if (!any_en) begin
      ramstate = FREE;
    end else if (done) begin
      ramstate = ACCESS;
    end
  end

  assign ramload = (done && cur_op == OP_RD) ? rdata : '0;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      phase    <= IDLE;
      cnt      <= '0;
      lat_addr <= '0;
      lat_op   <= OP_RD;
    end else begin
      unique case (1'b1)
        bad, !any_en: begin
          phase <= IDLE;
        end
        relatch: begin
          phase    <= WAIT;
          cnt      <= LOAD;
          lat_addr <= ramaddr;
          lat_op   <= cur_op;
        end
        count: begin
          cnt <= cnt - 4'd1;
        end
        done: begin
          phase <= IDLE;
        end
        default: begin
          phase <= IDLE;
        end
      endcase
    end
  end

  ram_array #(
    .ADDR_W(ADDR_W)
  ) u_array (
    .CLK  (CLK),
    .we   (we),
    .widx (idx),
    .wdata(ramstore),
    .ridx (idx),
    .rdata(rdata)
  );

endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder at LAT=1,2,3 sharing one stimulus.
// Transaction-level model: a request seen LAT+1 cycles in a row hits.
module tb_ram_responder;
  import cpu_types_pkg::*;

  logic  clk;
  logic  nrst;
  logic  ren;
  logic  wen;
  word_t addr;
  word_t store;

  word_t     load_o [3];
  ramstate_t st_o   [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ram_responder #(
      .LAT   (g + 1),
      .ADDR_W(10)
    ) dut (
      .CLK     (clk),
      .nRST    (nrst),
      .ramREN  (ren),
      .ramWEN  (wen),
      .ramaddr (addr),
      .ramstore(store),
      .ramload (load_o[g]),
      .ramstate(st_o[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  word_t mem   [3][1024];
  bit    pend  [3];
  int    age   [3];
  word_t paddr [3];
  bit    pwr   [3];

  task automatic cycle();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      ramstate_t es;
      word_t     el;
      bit        en;
      bit        lg;
      int        wi;
      en = ren || wen;
      lg = en && !(ren && wen) && (addr % 4 == 0)
           && (addr < 32'h1000);
      wi = int'(addr / 4);
      el = '0;
      if (en && !lg) begin
        es = ERROR;
        pend[k] = 0;
      end else if (!en) begin
        es = FREE;
        pend[k] = 0;
      end else begin
        if (pend[k] && paddr[k] == addr && pwr[k] == wen) begin
          age[k]++;
        end else begin
          pend[k]  = 1;
          age[k]   = 0;
          paddr[k] = addr;
          pwr[k]   = wen;
        end
        es = (age[k] == k + 1) ? ACCESS : BUSY;
        if (es == ACCESS && !wen) el = mem[k][wi];
      end
      checks++;
      assert (st_o[k] === es) else begin
        errors++;
        $error("FAIL state lat%0d cyc%0d: got %0d want %0d",
               k + 1, cyc, st_o[k], es);
      end
      checks++;
      assert (load_o[k] === el) else begin
        errors++;
        $error("FAIL load lat%0d cyc%0d: got %h want %h",
               k + 1, cyc, load_o[k], el);
      end
      if (es == ACCESS) begin
        pend[k] = 0;
        if (wen) mem[k][wi] = store;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic req(input bit r, input bit w,
                     input word_t a, input word_t d,
                     input int n);
    ren   = r;
    wen   = w;
    addr  = a;
    store = d;
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    ren  = 1'b0;
    wen  = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      assert (st_o[k] === FREE) else begin
        errors++;
        $error("FAIL rst_state lat%0d: got %0d want %0d",
               k + 1, st_o[k], FREE);
      end
      checks++;
      assert (load_o[k] === 32'h0) else begin
        errors++;
        $error("FAIL rst_load lat%0d: got %h want 0",
               k + 1, load_o[k]);
      end
      pend[k] = 0;
    end
    @(posedge clk);
    #1;
    nrst = 1'b1;
    cyc++;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      pend[k] = 0;
      age[k]  = 0;
      for (int i = 0; i < 1024; i++) mem[k][i] = '0;
    end
    nrst  = 1'b0;
    ren   = 1'b0;
    wen   = 1'b0;
    addr  = '0;
    store = '0;
    #1;
    do_reset();
    req(0, 0, 0, 0, 2);

    // write then read back
    req(0, 1, 32'h10, 32'hDEADBEEF, 4);
    req(1, 0, 32'h10, 0, 4);
    req(0, 0, 0, 0, 1);

    // address switch restarts latency
    req(0, 1, 32'h24, 32'hCAFE0009, 4);
    req(0, 0, 0, 0, 1);
    req(1, 0, 32'h20, 0, 2);
    req(1, 0, 32'h24, 0, 4);

    // errors write nothing
    req(1, 1, 32'h10, 32'h11111111, 1);
    req(0, 1, 32'h12, 32'h22222222, 1);
    req(1, 0, 32'h12, 0, 1);
    req(0, 1, 32'h1010, 32'h33333333, 1);
    req(0, 0, 0, 0, 1);
    req(1, 0, 32'h10, 0, 4);

    // back-to-back reads
    req(1, 0, 32'h0, 0, 4);
    req(1, 0, 32'h4, 0, 4);
    req(0, 0, 0, 0, 1);

    // reset mid-transaction drops the write
    req(0, 1, 32'h40, 32'h1234, 1);
    do_reset();
    req(1, 0, 32'h40, 0, 4);

    // abandon then full latency again
    req(1, 0, 32'h10, 0, 2);
    req(0, 0, 0, 0, 1);
    req(1, 0, 32'h10, 0, 4);

    // store wanders during BUSY
    ren  = 1'b0;
    wen  = 1'b1;
    addr = 32'h30;
    for (int i = 0; i < 4; i++) begin
      store = $urandom;
      cycle();
    end
    req(1, 0, 32'h30, 0, 4);

    // random traffic
    for (int t = 0; t < 60; t++) begin
      int    r;
      int    n;
      word_t a;
      r = $urandom_range(0, 9);
      n = $urandom_range(1, 5);
      a = 32'($urandom_range(0, 7)) * 4;
      case (r)
        0: req(0, 0, a, 0, n);
        1: req(1, 1, a, $urandom, n);
        2: req($urandom_range(0, 1) == 1, 1'b1,
               (n > 2) ? a + 2 : a + 32'h2000, $urandom, n);
        3, 4, 5: req(1, 0, a, 0, n);
        default: begin
          ren  = 1'b0;
          wen  = 1'b1;
          addr = a;
          store = $urandom;
          for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) store = $urandom;
            cycle();
          end
        end
      endcase
    end
    req(0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      req(1, 0, 32'(i) * 4, 0, 4);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
